// File: rtl/serial_adder_ctrl.sv
// Bit-serial LSB-first adder built around a single full-adder cell.
// One bit pair per clock; done pulses WIDTH+1 cycles after the accepted start.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_dbg
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-1:0] res_d;

    // Full-adder cell plus the right shifts; the new sum bit enters at the MSB
    // so after WIDTH shifts the first (LSB) result bit has reached bit 0.
    always_comb begin
        fa_s           = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_co          = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        a_sh_d         = a_sh_q >> 1;
        b_sh_d         = b_sh_q >> 1;
        res_d          = res_q >> 1;
        res_d[WIDTH-1] = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_d;
                    res_q   <= res_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_co;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a start, giving back-to-back throughput.
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1; expected results are
// queued when a start is driven and popped when done pulses.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic [1:0] st8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
    logic [1:0] st1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] exp8_q[$];
    logic [1:0] exp1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .state_dbg(st8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .state_dbg(st1)
    );

    // Waits at negedges until done is seen or the budget runs out.
    task automatic wait_done8(input int max_cyc, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (n < max_cyc && !seen) begin
            if (done8 === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic wait_done1(input int max_cyc, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (n < max_cyc && !seen) begin
            if (done1 === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            failures++;
            $display("FAIL reset8 got busy=%b done=%b cout=%b sum=%h exp all 0", busy8, done8, cout8, sum8);
        end
        checks++;
        if ({busy1, done1, cout1, sum1} !== 4'h0) begin
            failures++;
            $display("FAIL reset1 got busy=%b done=%b cout=%b sum=%h exp all 0", busy1, done1, cout1, sum1);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [8:0] e;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'h100);
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                failures++;
                $display("FAIL basic_busy cycle=%0d got busy=%b done=%b exp busy=1 done=0", i + 1, busy8, done8);
            end
            @(negedge clk);
        end
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_cycle9 got busy=%b done=%b exp busy=0 done=1", busy8, done8);
        end
        checks++;
        if (exp8_q.size() == 0) begin
            failures++;
            $display("FAIL basic_sb got empty expected queue");
        end else begin
            e = exp8_q.pop_front();
            if ({cout8, sum8} !== e) begin
                failures++;
                $display("FAIL basic_sb got %h exp %h", {cout8, sum8}, e);
            end
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            failures++;
            $display("FAIL basic_pulse got done=%b exp 0", done8);
        end
    endtask

    task automatic test_hold;
        logic [8:0] e;
        bit seen;
        a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b1; start8 = 1'b1;
        exp8_q.push_back(9'h080);
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(20, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL hold_timeout got no done exp done within 20 cycles");
        end
        checks++;
        if (exp8_q.size() == 0) begin
            failures++;
            $display("FAIL hold_sb got empty expected queue");
        end else begin
            e = exp8_q.pop_front();
            if ({cout8, sum8} !== e) begin
                failures++;
                $display("FAIL hold_sb got %h exp %h", {cout8, sum8}, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cout8, sum8} !== 9'h080) begin
                failures++;
                $display("FAIL hold_idle got %h exp 080", {cout8, sum8});
            end
        end
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'h003);
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({cout8, sum8} !== 9'h080) begin
                failures++;
                $display("FAIL hold_run got %h exp 080", {cout8, sum8});
            end
            @(negedge clk);
        end
        wait_done8(20, seen);
        checks++;
        if (exp8_q.size() == 0 || !seen) begin
            failures++;
            $display("FAIL hold_sb2 got seen=%b queue=%0d exp done with entry", seen, exp8_q.size());
        end else begin
            e = exp8_q.pop_front();
            if ({cout8, sum8} !== e) begin
                failures++;
                $display("FAIL hold_sb2 got %h exp %h", {cout8, sum8}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        logic [8:0] e;
        int pulses = 0;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'h030);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done8 === 1'b1) begin
                pulses++;
                checks++;
                if (exp8_q.size() == 0) begin
                    failures++;
                    $display("FAIL ignore_sb got empty expected queue");
                end else begin
                    e = exp8_q.pop_front();
                    if ({cout8, sum8} !== e) begin
                        failures++;
                        $display("FAIL ignore_sb got %h exp %h", {cout8, sum8}, e);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL ignore_pulses got %0d exp 1", pulses);
        end
    endtask

    task automatic test_reset_abort;
        logic [8:0] e;
        bit seen;
        a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
        exp8_q.push_back(9'h08E);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp8_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'h000) begin
            failures++;
            $display("FAIL abort_state got busy=%b done=%b cout=%b sum=%h exp all 0", busy8, done8, cout8, sum8);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL abort_quiet got busy=%b done=%b exp 0 0", busy8, done8);
            end
        end
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'h002);
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(20, seen);
        checks++;
        if (exp8_q.size() == 0 || !seen) begin
            failures++;
            $display("FAIL abort_sb got seen=%b queue=%0d exp done with entry", seen, exp8_q.size());
        end else begin
            e = exp8_q.pop_front();
            if ({cout8, sum8} !== e) begin
                failures++;
                $display("FAIL abort_sb got %h exp %h", {cout8, sum8}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [8:0] e;
        bit seen;
        int t1, t2;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        exp8_q.push_back(9'h046);
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(20, seen);
        t1 = cyc;
        checks++;
        if (exp8_q.size() == 0 || !seen) begin
            failures++;
            $display("FAIL b2b_sb1 got seen=%b queue=%0d exp done with entry", seen, exp8_q.size());
        end else begin
            e = exp8_q.pop_front();
            if ({cout8, sum8} !== e) begin
                failures++;
                $display("FAIL b2b_sb1 got %h exp %h", {cout8, sum8}, e);
            end
        end
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
        exp8_q.push_back(9'h101);
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_idle got busy=%b done=%b exp busy=1 done=0", busy8, done8);
        end
        wait_done8(20, seen);
        t2 = cyc;
        checks++;
        if (t2 - t1 != 9) begin
            failures++;
            $display("FAIL b2b_spacing got %0d exp 9", t2 - t1);
        end
        checks++;
        if (exp8_q.size() == 0 || !seen) begin
            failures++;
            $display("FAIL b2b_sb2 got seen=%b queue=%0d exp done with entry", seen, exp8_q.size());
        end else begin
            e = exp8_q.pop_front();
            if ({cout8, sum8} !== e) begin
                failures++;
                $display("FAIL b2b_sb2 got %h exp %h", {cout8, sum8}, e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random8;
        logic [8:0] e;
        bit seen;
        bit b2b = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
            exp8_q.push_back(9'(a8) + 9'(b8) + 9'(cin8));
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
            wait_done8(20, seen);
            checks++;
            if (exp8_q.size() == 0 || !seen) begin
                failures++;
                $display("FAIL rand8_sb n=%0d got seen=%b queue=%0d exp done with entry", n, seen, exp8_q.size());
                exp8_q.delete();
            end else begin
                e = exp8_q.pop_front();
                if ({cout8, sum8} !== e) begin
                    failures++;
                    $display("FAIL rand8_sb n=%0d got %h exp %h", n, {cout8, sum8}, e);
                end
            end
            b2b = ($urandom_range(0, 3) == 0);
            if (!b2b) begin
                @(negedge clk);
                checks++;
                if (done8 !== 1'b0) begin
                    failures++;
                    $display("FAIL rand8_double_done n=%0d got done=%b exp 0", n, done8);
                end
            end
        end
        if (b2b) @(negedge clk);
    endtask

    task automatic test_random1;
        logic [1:0] e;
        bit seen;
        bit b2b = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (!b2b) repeat ($urandom_range(0, 3)) @(negedge clk);
            a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
            cin1 = 1'($urandom_range(0, 1));
            exp1_q.push_back(2'(a1) + 2'(b1) + 2'(cin1));
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0; a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
            checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                failures++;
                $display("FAIL rand1_busy n=%0d got busy=%b done=%b exp 1 0", n, busy1, done1);
            end
            @(negedge clk);
            wait_done1(5, seen);
            checks++;
            if (exp1_q.size() == 0 || !seen) begin
                failures++;
                $display("FAIL rand1_sb n=%0d got seen=%b queue=%0d exp done with entry", n, seen, exp1_q.size());
                exp1_q.delete();
            end else begin
                e = exp1_q.pop_front();
                if ({cout1, sum1} !== e) begin
                    failures++;
                    $display("FAIL rand1_sb n=%0d got %h exp %h", n, {cout1, sum1}, e);
                end
            end
            b2b = ($urandom_range(0, 3) == 0);
            if (!b2b) begin
                @(negedge clk);
                checks++;
                if (done1 !== 1'b0) begin
                    failures++;
                    $display("FAIL rand1_double_done n=%0d got done=%b exp 0", n, done1);
                end
            end
        end
        if (b2b) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random8();
        test_random1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
